// File: rtl/exception_pkg.sv
// exception_pkg: shared constants for exception_monitor.
//   - load-immediate opcode / source field values
//   - exception cause encoding and exception FSM state type
//   - per-program tables: divisor byte count, capture register per byte,
//     divide-entry check PC (indexed by ProgState, entry 0 = idle)
package exception_pkg;

  localparam logic [2:0] LDI_OPCODE = 3'b000;
  localparam logic [2:0] LDI_SRC    = 3'b111;

  // Number of byte slots the tables below describe per program.
  localparam int TBL_MAX_BYTES = 2;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_DIV0    = 2'b01,
    CAUSE_ILLEGAL = 2'b10,
    CAUSE_UNINIT  = 2'b11
  } exc_cause_t;

  typedef enum logic {
    ST_CLEAR   = 1'b0,
    ST_PENDING = 1'b1
  } exc_state_t;

  // Packed tables, highest program first in each concatenation.
  localparam logic [3:0][1:0] BYTES = {2'd0, 2'd1, 2'd2, 2'd0};

  // CAPTURE_REG[p][k]: destination register feeding byte k of program p.
  localparam logic [3:0][1:0][2:0] CAPTURE_REG = {
    {3'd0, 3'd0},   // program 3: no bytes
    {3'd0, 3'd2},   // program 2: byte0 <- R2
    {3'd1, 3'd0},   // program 1: byte0 <- R0, byte1 <- R1
    {3'd0, 3'd0}    // idle
  };

  localparam logic [3:0][9:0] CHECK_PC = {
    10'b00000_00000,  // program 3: unused (no bytes, no check)
    10'b00100_00110,  // program 2
    10'b00001_10011,  // program 1
    10'b00000_00000   // idle
  };

endpackage

// File: rtl/exception_monitor_divisor_capture.sv
// divisor_capture: per-program divisor byte bank.
//   i_clk, i_rst    : clock, async active-high reset
//   i_clear         : clear all bytes and captured bits this cycle
//   i_cap_en        : a legal, non-changing program may capture this cycle
//   i_ldi           : current instruction is a load-immediate
//   i_dest          : load-immediate destination register
//   i_data          : immediate data
//   i_prog          : active program (table index)
//   o_all_zero      : every byte used by i_prog is zero (registered view)
//   o_all_captured  : every byte used by i_prog has been written
// Byte 0 is the most significant divisor byte; only the zero test is
// needed here so the ordering does not affect the outputs.
// MAX_BYTES must not exceed exception_pkg::TBL_MAX_BYTES.
module divisor_capture
  import exception_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BYTES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_cap_en,
  input  logic              i_ldi,
  input  logic [2:0]        i_dest,
  input  logic [DATA_W-1:0] i_data,
  input  logic [1:0]        i_prog,
  output logic              o_all_zero,
  output logic              o_all_captured
);

  logic [DATA_W-1:0]    r_bytes [MAX_BYTES];
  logic [MAX_BYTES-1:0] r_captured;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < MAX_BYTES; k++) r_bytes[k] <= '0;
      r_captured <= '0;
    end else if (i_clear) begin
      for (int k = 0; k < MAX_BYTES; k++) r_bytes[k] <= '0;
      r_captured <= '0;
    end else if (i_cap_en && i_ldi) begin
      for (int k = 0; k < MAX_BYTES; k++) begin
        if (k < int'(BYTES[i_prog]) && i_dest == CAPTURE_REG[i_prog][k]) begin
          r_bytes[k]    <= i_data;
          r_captured[k] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_all_zero     = 1'b1;
    o_all_captured = 1'b1;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (k < int'(BYTES[i_prog])) begin
        if (r_bytes[k] != '0) o_all_zero = 1'b0;
        if (!r_captured[k])   o_all_captured = 1'b0;
      end
    end
  end

endmodule

// File: rtl/exception_monitor.sv
// exception_monitor: snoops the fetch stream, captures each program's
// divisor bytes and raises exceptions (divide by zero, uninitialised
// divisor, illegal ProgState) through a valid/ack handshake.
//   CLK, Reset   : clock, async active-high reset
//   ProgState    : active program, 0 = idle, > NUM_PROGS = illegal
//   Instruction  : executing instruction; PC: its address
//   DataIn       : immediate data presented with load-immediate
//   exc_ack      : consumer accepts pending exception
//   exc_valid    : exception pending (halt_req mirrors it)
//   exc_cause    : 01 div0, 10 illegal state, 11 uninitialised divisor
//   exc_pc       : PC at detection of the pending exception
//   exc_overrun  : events were dropped while pending
//   exc_count    : saturating count of all events since reset
// Handshake: exc_valid stays high with cause/pc stable until a cycle with
// exc_ack = 1; that edge retires the exception. Ack while idle is ignored.
module exception_monitor
  import exception_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int INSTR_W   = 9,
  parameter int PC_W      = 10,
  parameter int NUM_PROGS = 3,
  parameter int MAX_BYTES = 2,
  parameter int CNT_W     = 8
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [1:0]         ProgState,
  input  logic [INSTR_W-1:0] Instruction,
  input  logic [DATA_W-1:0]  DataIn,
  input  logic [PC_W-1:0]    PC,
  input  logic               exc_ack,
  output logic               exc_valid,
  output logic [1:0]         exc_cause,
  output logic [PC_W-1:0]    exc_pc,
  output logic               exc_overrun,
  output logic [CNT_W-1:0]   exc_count,
  output logic               halt_req
);

  logic [1:0]       r_prev_state;
  logic             r_pc_hit;      // PC was at the check PC last cycle
  exc_state_t       r_state, w_next_state;
  exc_cause_t       r_cause, w_next_cause, w_ev_cause;
  logic [PC_W-1:0]  r_pc, w_next_pc;
  logic             r_overrun, w_next_overrun;
  logic [CNT_W-1:0] r_count, w_next_count;

  logic w_change, w_illegal, w_legal, w_ldi, w_pc_hit, w_check;
  logic w_all_zero, w_all_captured, w_event;

  assign w_change  = (ProgState != r_prev_state);
  assign w_illegal = (int'(ProgState) > NUM_PROGS);
  assign w_legal   = (ProgState != 2'd0) && !w_illegal;
  assign w_ldi     = (Instruction[8:6] == LDI_OPCODE) &&
                     (Instruction[2:0] == LDI_SRC);
  assign w_pc_hit  = (PC == PC_W'(CHECK_PC[ProgState]));

  divisor_capture #(
    .DATA_W    (DATA_W),
    .MAX_BYTES (MAX_BYTES)
  ) u_capture (
    .i_clk          (CLK),
    .i_rst          (Reset),
    .i_clear        (w_change || (ProgState == 2'd0)),
    .i_cap_en       (w_legal && !w_change),
    .i_ldi          (w_ldi),
    .i_dest         (Instruction[5:3]),
    .i_data         (DataIn),
    .i_prog         (ProgState),
    .o_all_zero     (w_all_zero),
    .o_all_captured (w_all_captured)
  );

  // Check fires on the first cycle of a run at the check PC; the arm
  // (r_pc_hit) is forced low in a program-change cycle.
  assign w_check = w_legal && !w_change && w_pc_hit && !r_pc_hit &&
                   (BYTES[ProgState] != 2'd0);

  always_comb begin
    w_event    = 1'b1;
    w_ev_cause = CAUSE_NONE;
    if (w_illegal && w_change)                     w_ev_cause = CAUSE_ILLEGAL;
    else if (w_check && !w_all_captured)           w_ev_cause = CAUSE_UNINIT;
    else if (w_check && w_all_zero)                w_ev_cause = CAUSE_DIV0;
    else                                           w_event    = 1'b0;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_prev_state <= '0;
      r_pc_hit     <= 1'b0;
      r_state      <= ST_CLEAR;
      r_cause      <= CAUSE_NONE;
      r_pc         <= '0;
      r_overrun    <= 1'b0;
      r_count      <= '0;
    end else begin
      r_prev_state <= ProgState;
      r_pc_hit     <= w_change ? 1'b0 : w_pc_hit;
      r_state      <= w_next_state;
      r_cause      <= w_next_cause;
      r_pc         <= w_next_pc;
      r_overrun    <= w_next_overrun;
      r_count      <= w_next_count;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_next_cause   = r_cause;
    w_next_pc      = r_pc;
    w_next_overrun = r_overrun;
    w_next_count   = (w_event && (r_count != '1)) ? r_count + CNT_W'(1) : r_count;
    case (r_state)
      ST_CLEAR: begin
        if (w_event) begin
          w_next_state   = ST_PENDING;
          w_next_cause   = w_ev_cause;
          w_next_pc      = PC;
          w_next_overrun = 1'b0;
        end
      end
      ST_PENDING: begin
        if (exc_ack && w_event) begin
          w_next_cause   = w_ev_cause;
          w_next_pc      = PC;
          w_next_overrun = 1'b0;
        end else if (exc_ack) begin
          w_next_state   = ST_CLEAR;
          w_next_cause   = CAUSE_NONE;
          w_next_pc      = '0;
          w_next_overrun = 1'b0;
        end else if (w_event) begin
          w_next_overrun = 1'b1;
        end
      end
      default: w_next_state = ST_CLEAR;
    endcase
  end

  assign exc_valid   = (r_state == ST_PENDING);
  assign halt_req    = exc_valid;
  assign exc_cause   = r_cause;
  assign exc_pc      = r_pc;
  assign exc_overrun = r_overrun;
  assign exc_count   = r_count;

endmodule

// File: doc/exception_monitor.md
# exception_monitor

Parametrised successor to the single-program divide-by-zero checker. It snoops the fetch stream: `Instruction`, `PC`, and the `DataIn` value presented on load-immediate. It captures each program's divisor bytes and flags a zero divisor when the program reaches its divide entry PC. It also flags an uninitialised divisor and an illegal `ProgState`, and reports exceptions to the top level through a valid/ack handshake with cause, PC, overrun flag and a saturating count.

## Interface
- `DATA_W`, 8: width of `DataIn` and of one divisor byte
- `INSTR_W`, 9: instruction width
- `PC_W`, 10: program counter width
- `NUM_PROGS`, 3: number of programs; legal `ProgState` is 0 (idle) to `NUM_PROGS`
- `MAX_BYTES`, 2: maximum divisor bytes per program
- `CNT_W`, 8: width of `exc_count`
- `CLK`, in, 1: clock. The block uses one clock only.
- `Reset`, in, 1: asynchronous reset, active-high
- `ProgState`, in, 2: current program; 0 means idle
- `Instruction`, in, `INSTR_W`: instruction currently executing
- `DataIn`, in, `DATA_W`: immediate data presented with load-immediate
- `PC`, in, `PC_W`: PC of `Instruction`
- `exc_ack`, in, 1: consumer accepts the pending exception
- `exc_valid`, out, 1: an exception is pending
- `exc_cause`, out, 2: cause code. 01 = divide by zero, 10 = illegal state, 11 = uninitialised divisor.
- `exc_pc`, out, `PC_W`: PC at which the pending exception was detected
- `exc_overrun`, out, 1: one or more events were dropped while an exception was pending
- `exc_count`, out, `CNT_W`: total exception events since reset; saturates at all-ones
- `halt_req`, out, 1: equal to `exc_valid`

## Operation
- **Load-immediate decode.** Opcode bits [8:6] = 000 and source bits [2:0] = 111. Destination register = bits [5:3].
- **Capture.** In program p, a load-immediate whose destination equals `CAPTURE_REG[p][k]`, for k < `BYTES[p]`, writes `DataIn` into byte k. It also sets `captured[k]`.
  - Byte 0 is the most significant.
  - Writes to any other destination are ignored.
- **Program change.** When `ProgState` differs from its registered previous value, all bytes and all `captured` bits clear.
  - The check arm also resets.
  - No capture occurs in the change cycle.
- **Idle.** While `ProgState` = 0, the capture bank is held clear.
- **Check.** A check event fires on the first cycle of each consecutive run of cycles with `PC` = `CHECK_PC[p]`. It applies only to programs with `BYTES[p]` > 0.
  - If any needed `captured` bit is 0, the cause is 11.
  - Otherwise, if all needed bytes are zero, the cause is 01.
  - Otherwise no event.
  - The check uses registered values, so a capture in the same cycle is not seen.
- **Illegal state.** `ProgState` > `NUM_PROGS` is an event with cause 10, once per entry into the illegal value. While illegal, no capture and no check.
- **Exception FSM, two states.** State CLEAR: `exc_valid` = 0. State PENDING: `exc_valid` = 1.
  - CLEAR to PENDING: on an event, latch cause and `PC`.
  - PENDING to CLEAR: on `exc_ack` with no new event.
  - PENDING with `exc_ack` and a new event in the same cycle: load the new event, stay PENDING, and clear `exc_overrun`.
  - PENDING with a new event and no ack: keep the latched cause and PC, and set `exc_overrun`.
  - `exc_overrun` clears on ack.
- **Counting.** `exc_count` increments on every event, dropped events included, and saturates.
- **Priority.** At most one event per cycle. If more than one is detected, priority is 10 > 11 > 01.

## Timing
- **Reset values.** All outputs are 0. Capture bank, `captured` bits, previous-state register and check arm are all 0.
- Capture is visible to the check one cycle after the load-immediate cycle.
- An event detected in cycle n gives `exc_valid` = 1 after the edge ending cycle n. Latency is 1 cycle.
- `exc_valid` drops at the edge that samples `exc_ack` = 1.
- `exc_ack` while CLEAR is ignored.
- `Reset` asserted mid-operation clears everything immediately, including a pending exception.

## Structure
- **Package `exception_pkg`** holds:
  - the load-immediate opcode and source field constants;
  - the cause enum `exc_cause_t`;
  - the per-program tables `BYTES`, `CAPTURE_REG` and `CHECK_PC`.
- **Table contents:**
  - Program 1: 2 bytes, from R0 then R1; check PC 10'b00001_10011.
  - Program 2: 1 byte, from R2; check PC 10'b00100_00110.
  - Program 3: 0 bytes; no check.
- **Sub-module `divisor_capture`** holds the `MAX_BYTES` byte registers and `captured` bits, with the capture and clear logic. It outputs `all_zero` and `all_captured` for the active program.

## Test plan
- **Program 1, zero divisor.** `ProgState` = 1. Load-immediate R0 with 0x00, then R1 with 0x00. Then `PC` = 0x033 for 3 cycles. Expect `exc_valid` = 1 one cycle later, cause 01, `exc_pc` 0x033, count 1, exactly one event.
- **Program 1, non-zero divisor.** R0 = 0x00, R1 = 0x05, then `PC` = 0x033. Expect no exception. Then switch to `ProgState` = 2 and go to `PC` = 0x086 without loading R2. Expect cause 11.
- **Same-cycle capture.** Program 2: load-immediate R2 with 0x00 in the same cycle that `PC` = 0x086. Expect cause 11, because the capture is not yet visible.
- **Illegal state and overrun.** Hold an exception pending with no ack, then drive `ProgState` = 3 with `NUM_PROGS` = 2.
  - Expect the original cause kept, `exc_overrun` = 1 and count 2.
  - Ack: `exc_valid` and `exc_overrun` go to 0.
- **Simultaneous ack and event.** Ack in the same cycle as a new zero-divisor event. Expect `exc_valid` to stay 1 with the new `exc_pc`, and `exc_overrun` = 0.
- **Reset and saturation.** Assert `Reset` while PENDING: all outputs 0 immediately. Separately, drive 300 events with `CNT_W` = 8: `exc_count` holds at 255.
